data_ram_banked: RTL and testbench
==================================

DATA_RAM_BANKED -- requirements
Module: data_ram_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; power of two, minimum 2.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL derive internally: NB = DATA_W/8 lanes; OFS = log2(NB); IDX = log2(DEPTH).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  byte address; bits [OFS-1:0] ignored.
REQ-011 req_sel  input  NB  byte-lane enables; bit k covers data bits [8k+7:8k].
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-015 rsp_rdata  output  DATA_W  read data; zero for writes and errors.
REQ-016 rsp_err  output  1  request was rejected (see REQ-022).

Function
REQ-017 Storage SHALL be NB independent byte banks of DEPTH entries, word index = req_addr[OFS+IDX-1:OFS].
REQ-018 Request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-019 req_ready SHALL be combinational: 1 when rsp_valid=0 or rsp_ready=1; 0 during reset.
REQ-020 Every accepted request SHALL produce exactly one response, rsp_valid=1 on the cycle after acceptance (latency 1).
REQ-021 Accepted write SHALL update, on the accept edge, only banks whose req_sel bit is 1; other banks unchanged.
REQ-022 Request SHALL be an error if req_addr[ADDR_W-1:OFS+IDX] is nonzero (out of range) or req_sel is all zero; error write SHALL modify no bank; response rsp_err=1, rsp_rdata=0.
REQ-023 Accepted read SHALL register bank contents at the accept edge; lanes with req_sel=0 SHALL return 0 in rsp_rdata.
REQ-024 Read accepted the cycle after a write to the same word SHALL return the newly written bytes (write completed on the earlier edge).
REQ-025 Response registers (rsp_valid, rsp_rdata, rsp_err) SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-026 On rsp_valid=1 and rsp_ready=1 with a new request accepted the same edge, the new response SHALL replace the old one with no bubble (full throughput, one request per cycle).
REQ-027 On rsp_valid=1, rsp_ready=1 and no new request, rsp_valid SHALL go 0 on that edge.
REQ-028 Control SHALL be a two-state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL on accept or stall.
REQ-029 req_* inputs SHALL be ignored when no acceptance occurs; no bank may change.
REQ-030 Bank contents SHALL be undefined after power-up; no initialisation logic.

Reset
REQ-031 rst=0 SHALL immediately force rsp_valid=0, rsp_err=0, rsp_rdata=0, state EMPTY, req_ready=0, regardless of clk.
REQ-032 Reset SHALL not alter bank contents; a response pending at reset assertion SHALL be discarded.
REQ-033 After rst deasserts, req_ready SHALL be 1 from the first following cycle.

Verification
REQ-034 Write addr 0x10, sel 4'b1111, data 0xDEADBEEF; then read addr 0x10, sel 4'b1111 -> read response next cycle rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Write 0x11223344 to 0x20 sel 1111; write 0xAABBCCDD sel 0101; read sel 1111 -> 0x11BB33DD; read sel 0011 -> 0x000033DD.
REQ-036 Default params, write addr 0x00001000 (word 1024) data 0xFFFFFFFF -> rsp_err=1, rsp_rdata=0; read word 0 unchanged; request with sel=0000 -> rsp_err=1.
REQ-037 Hold rsp_ready=0 for 3 cycles after a read -> rsp_valid, rsp_rdata stable, req_ready=0; then rsp_ready=1 with back-to-back reads to 0x10, 0x14 -> one response per cycle, correct data.
REQ-038 Assert rst=0 mid-cycle while rsp_valid=1 -> outputs zero before next edge; after release, prior written data still readable.
REQ-039 Rerun REQ-034/036 with DATA_W=64, DEPTH=16: write addr 0x08 sel 0xFF data 0x0123456789ABCDEF reads back; addr 0x80 -> rsp_err=1.

Source files
------------

// File: rtl/data_ram_banked_if.sv
// Request/response bus of the banked data RAM: one valid/ready request channel
// and one valid/ready response channel.
interface data_ram_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [NB-1:0]     req_sel;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_ram_banked.sv
// Byte-banked single-port data RAM with a one-deep registered response stage;
// one request per cycle, read latency of one cycle, byte-lane write enables.
module data_ram_banked #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_banked_if.slave bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);
  localparam int TOP = OFS + IDX;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e            state_q, state_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              req_ready;
  logic              accept;
  logic              out_of_range;
  logic              req_err;
  logic              do_write;
  logic              do_read;
  logic [IDX-1:0]    word_idx;
  logic [NB-1:0][7:0] rd_lane;

  assign word_idx = bus.req_addr[TOP-1:OFS];

  generate
    if (ADDR_W > TOP) begin : g_hi
      assign out_of_range = |bus.req_addr[ADDR_W-1:TOP];
    end else begin : g_no_hi
      assign out_of_range = 1'b0;
    end
    if (OFS > 0) begin : g_ofs
      // Byte offset within a word carries no information for this RAM.
      logic unused_ofs;
      assign unused_ofs = ^bus.req_addr[OFS-1:0];
    end
  endgenerate

  // Ready is held low throughout reset so nothing can be accepted or written.
  assign req_ready = rst && ((state_q == ST_EMPTY) || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign req_err   = out_of_range || (bus.req_sel == '0);
  assign do_write  = accept && bus.req_we && !req_err;
  assign do_read   = accept && !bus.req_we && !req_err;

  generate
    for (genvar k = 0; k < NB; k++) begin : g_bank
      logic [7:0] mem [DEPTH];

      // NOTE: bank storage has no reset; contents survive rst and start undefined.
      always_ff @(posedge clk) begin
        if (do_write && bus.req_sel[k]) begin
          mem[word_idx] <= bus.req_wdata[8*k +: 8];
        end
      end

      assign rd_lane[k] = (do_read && bus.req_sel[k]) ? mem[word_idx] : 8'h00;
    end
  endgenerate

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d     = state_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && bus.rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    // A new response overwrites the slot; otherwise it holds through a stall.
    if (accept) begin
      rsp_err_d   = req_err;
      rsp_rdata_d = rd_lane;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_ram_banked.sv
// Bench for data_ram_banked: directed vector table on a 32-bit and a 64-bit
// instance, stall/reset sequences, then randomized traffic against a word model.
module tb_data_ram_banked;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_ram_banked_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  data_ram_banked_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  data_ram_banked #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  data_ram_banked #(.DATA_W(64), .DEPTH(16), .ADDR_W(32)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  typedef struct {
    bit          wide;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  sel;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit wide, input logic we, input logic [31:0] addr,
                     input logic [7:0] sel, input logic [63:0] wdata,
                     input logic [63:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.wide = wide; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] init_val(input int w);
    return 32'hA0B0C0D0 + 32'(w) * 32'h01010101;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (sel[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // One request with the response channel ready; checks acceptance and response.
  task automatic issue(input vec_t v);
    @(negedge clk);
    if (v.wide) begin
      b64.req_valid = 1'b1; b64.req_we = v.we; b64.req_addr = v.addr;
      b64.req_sel = v.sel; b64.req_wdata = v.wdata; b64.rsp_ready = 1'b1;
      #1 check({v.name, "_ready"}, 64'(b64.req_ready), 64'd1);
    end else begin
      b32.req_valid = 1'b1; b32.req_we = v.we; b32.req_addr = v.addr;
      b32.req_sel = v.sel[3:0]; b32.req_wdata = v.wdata[31:0]; b32.rsp_ready = 1'b1;
      #1 check({v.name, "_ready"}, 64'(b32.req_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    if (v.wide) begin
      b64.req_valid = 1'b0;
      check({v.name, "_valid"}, 64'(b64.rsp_valid), 64'd1);
      check({v.name, "_rdata"}, b64.rsp_rdata, v.exp_rdata);
      check({v.name, "_err"},   64'(b64.rsp_err), 64'(v.exp_err));
    end else begin
      b32.req_valid = 1'b0;
      check({v.name, "_valid"}, 64'(b32.rsp_valid), 64'd1);
      check({v.name, "_rdata"}, 64'(b32.rsp_rdata), v.exp_rdata);
      check({v.name, "_err"},   64'(b32.rsp_err), 64'(v.exp_err));
    end
  endtask

  task automatic issue32(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input string name);
    vec_t v;
    v.wide = 1'b0; v.we = we; v.addr = addr; v.sel = {4'h0, sel}; v.wdata = 64'(wdata);
    v.exp_rdata = 64'(exp_rdata); v.exp_err = exp_err; v.name = name;
    issue(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        have;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        err;
    int          w;
    int          bitpos;

    b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_addr = '0;
    b32.req_sel = '0; b32.req_wdata = '0; b32.rsp_ready = 1'b1;
    b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_addr = '0;
    b64.req_sel = '0; b64.req_wdata = '0; b64.rsp_ready = 1'b1;

    // Reset state
    #3;
    check("rst_valid",   64'(b32.rsp_valid), 64'd0);
    check("rst_rdata",   64'(b32.rsp_rdata), 64'd0);
    check("rst_err",     64'(b32.rsp_err),   64'd0);
    check("rst_ready",   64'(b32.req_ready), 64'd0);
    check("rst_ready64", 64'(b64.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rel_ready", 64'(b32.req_ready), 64'd1);

    // Directed vector table
    add(0, 1, 32'h10,   8'h0F, 64'hDEADBEEF, 64'h0,        0, "w_10");
    add(0, 0, 32'h10,   8'h0F, 64'h0,        64'hDEADBEEF, 0, "r_10");
    add(0, 1, 32'h20,   8'h0F, 64'h11223344, 64'h0,        0, "w_20_full");
    add(0, 1, 32'h20,   8'h05, 64'hAABBCCDD, 64'h0,        0, "w_20_sel5");
    add(0, 0, 32'h20,   8'h0F, 64'h0,        64'h11BB33DD, 0, "r_20_full");
    add(0, 0, 32'h20,   8'h03, 64'h0,        64'h000033DD, 0, "r_20_sel3");
    add(0, 1, 32'h00,   8'h0F, 64'h0BADF00D, 64'h0,        0, "w_00");
    add(0, 1, 32'h1000, 8'h0F, 64'hFFFFFFFF, 64'h0,        1, "w_oor");
    add(0, 0, 32'h00,   8'h0F, 64'h0,        64'h0BADF00D, 0, "r_00_kept");
    add(0, 0, 32'h13,   8'h0F, 64'h0,        64'hDEADBEEF, 0, "r_13_ofs");
    add(0, 1, 32'h10,   8'h00, 64'h12345678, 64'h0,        1, "w_sel0");
    add(0, 0, 32'h10,   8'h00, 64'h0,        64'h0,        1, "r_sel0");
    add(0, 0, 32'h10,   8'h0F, 64'h0,        64'hDEADBEEF, 0, "r_10_kept");
    add(0, 0, 32'h1000, 8'h0F, 64'h0,        64'h0,        1, "r_oor");
    add(0, 1, 32'hFFC,  8'h0F, 64'h5A5A5A5A, 64'h0,        0, "w_top");
    add(0, 0, 32'hFFC,  8'h0F, 64'h0,        64'h5A5A5A5A, 0, "r_top");
    add(1, 1, 32'h08,   8'hFF, 64'h0123456789ABCDEF, 64'h0, 0, "w64_08");
    add(1, 0, 32'h08,   8'hFF, 64'h0, 64'h0123456789ABCDEF, 0, "r64_08");
    add(1, 1, 32'h00,   8'hFF, 64'h1111111111111111, 64'h0, 0, "w64_00");
    add(1, 1, 32'h80,   8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, "w64_oor");
    add(1, 0, 32'h00,   8'hFF, 64'h0, 64'h1111111111111111, 0, "r64_00_kept");
    add(1, 0, 32'h08,   8'h0F, 64'h0, 64'h0000000089ABCDEF, 0, "r64_08_lo");
    add(1, 1, 32'h78,   8'hF0, 64'hAAAAAAAABBBBBBBB, 64'h0, 0, "w64_top_hi");
    add(1, 0, 32'h78,   8'hF0, 64'h0, 64'hAAAAAAAA00000000, 0, "r64_top_hi");
    add(1, 0, 32'h7F,   8'h00, 64'h0, 64'h0,                1, "r64_sel0");
    foreach (vecs[i]) issue(vecs[i]);

    // Known contents for words 0..15 of the 32-bit instance
    for (int i = 0; i < 16; i++) begin
      model[i] = init_val(i);
      issue32(1'b1, 32'(i * 4), 4'hF, init_val(i), 32'h0, 1'b0, "init_wr");
    end

    // Stall: response held for 3 cycles while a write request is offered
    @(negedge clk);
    b32.req_valid = 1'b1; b32.req_we = 1'b0; b32.req_addr = 32'h10;
    b32.req_sel = 4'hF; b32.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    b32.rsp_ready = 1'b0; b32.req_we = 1'b1; b32.req_addr = 32'h14; b32.req_wdata = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(b32.rsp_valid), 64'd1);
      check("stall_rdata", 64'(b32.rsp_rdata), 64'(init_val(4)));
      check("stall_ready", 64'(b32.req_ready), 64'd0);
    end
    @(negedge clk);
    b32.rsp_ready = 1'b1; b32.req_we = 1'b0; b32.req_addr = 32'h10;
    #1 check("unstall_ready", 64'(b32.req_ready), 64'd1);
    @(negedge clk);
    check("b2b0_valid", 64'(b32.rsp_valid), 64'd1);
    check("b2b0_rdata", 64'(b32.rsp_rdata), 64'(init_val(4)));
    b32.req_addr = 32'h14;
    @(negedge clk);
    check("b2b1_valid", 64'(b32.rsp_valid), 64'd1);
    check("b2b1_rdata", 64'(b32.rsp_rdata), 64'(init_val(5)));
    b32.req_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", 64'(b32.rsp_valid), 64'd0);

    // Reset asserted mid-cycle with a response pending
    @(negedge clk);
    b32.req_valid = 1'b1; b32.req_we = 1'b0; b32.req_addr = 32'h0C; b32.req_sel = 4'hF;
    @(posedge clk);
    #1;
    b32.rsp_ready = 1'b0; b32.req_we = 1'b1; b32.req_wdata = 32'h0;
    @(negedge clk);
    check("prerst_valid", 64'(b32.rsp_valid), 64'd1);
    check("prerst_rdata", 64'(b32.rsp_rdata), 64'(init_val(3)));
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", 64'(b32.rsp_valid), 64'd0);
    check("midrst_rdata", 64'(b32.rsp_rdata), 64'd0);
    check("midrst_err",   64'(b32.rsp_err),   64'd0);
    check("midrst_ready", 64'(b32.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; b32.req_valid = 1'b0; b32.rsp_ready = 1'b1;
    #1 check("postrst_ready", 64'(b32.req_ready), 64'd1);
    issue32(1'b0, 32'h0C, 4'hF, 32'h0, init_val(3), 1'b0, "rst_data_kept");
    @(posedge clk);

    // Randomized traffic against the word model
    have = 1'b0;
    exp_rdata = '0;
    exp_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check("rnd_valid", 64'(b32.rsp_valid), 64'(have));
      if (have) begin
        check("rnd_rdata", 64'(b32.rsp_rdata), 64'(exp_rdata));
        check("rnd_err",   64'(b32.rsp_err),   64'(exp_err));
      end
      b32.req_valid = ($urandom_range(0, 3) != 0);
      b32.rsp_ready = ($urandom_range(0, 3) != 0);
      b32.req_we    = 1'($urandom_range(0, 1));
      b32.req_sel   = 4'($urandom_range(0, 15));
      b32.req_wdata = $urandom;
      b32.req_addr  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) begin
        bitpos = $urandom_range(12, 31);
        b32.req_addr[bitpos] = 1'b1;
      end
      #1 check("rnd_ready", 64'(b32.req_ready), 64'(!have || b32.rsp_ready));
      @(posedge clk);
      if (b32.req_valid && (!have || b32.rsp_ready)) begin
        err = (b32.req_addr >= 32'h1000) || (b32.req_sel == 4'h0);
        w   = int'(b32.req_addr / 4) % 16;
        exp_err   = err;
        exp_rdata = (err || b32.req_we) ? 32'h0 : (model[w] & lane_mask(b32.req_sel));
        if (b32.req_we && !err) begin
          model[w] = (model[w] & ~lane_mask(b32.req_sel)) |
                     (b32.req_wdata & lane_mask(b32.req_sel));
        end
        have = 1'b1;
      end else if (have && b32.rsp_ready) begin
        have = 1'b0;
      end
    end
    @(negedge clk);
    b32.req_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
